// File: rtl/pipelined_control_unit_if.sv
// Decode-to-control and control-to-execute handshake bundle.
// master: environment side; slave: control unit side.
interface pipelined_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [OPCODE_W-1:0] funct;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic                out_valid;
  logic                out_ready;
  logic                reg_dst;
  logic                branch;
  logic                mem_read;
  logic                mem_to_reg;
  logic                mem_write;
  logic                alu_src;
  logic                reg_write;
  logic [1:0]          alu_op;
  logic [REG_W-1:0]    dest_reg;
  logic                illegal;
  logic                illegal_seen;

  modport master (
    output in_valid, opcode, funct, rs, rt, rd, out_ready,
    input  in_ready, out_valid, reg_dst, branch, mem_read,
    input  mem_to_reg, mem_write, alu_src, reg_write,
    input  alu_op, dest_reg, illegal, illegal_seen
  );

  modport slave (
    input  in_valid, opcode, funct, rs, rt, rd, out_ready,
    output in_ready, out_valid, reg_dst, branch, mem_read,
    output mem_to_reg, mem_write, alu_src, reg_write,
    output alu_op, dest_reg, illegal, illegal_seen
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered control decoder with load-use bubble, MUL stall and flush.
// CU_ILLEGAL_TRAP_EN enables the illegal / illegal_seen trap outputs.
module pipelined_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  pipelined_control_unit_if.slave bus
);

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(6'h2B);
  localparam logic [OPCODE_W-1:0] FUNCT_MUL = OPCODE_W'(2);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_MUL = 1'b1;

  localparam int CNT_W =
    (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MUL_CYCLES - 1);
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [REG_W-1:0] dest_q, dest_d;

  ctrl_t            dec;
  logic             dec_illegal;
  logic             rt_used;
  logic             is_rtype;
  logic             hazard;
  logic             in_ready;
  logic             accept;
  logic             is_mul;

  assign is_rtype = (bus.opcode == OP_RTYPE);

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    rt_used     = 1'b0;
    unique case (1'b1)
      is_rtype: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        rt_used       = 1'b1;
      end
      (bus.opcode == OP_LW): begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      (bus.opcode == OP_SW): begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        rt_used       = 1'b1;
      end
      (bus.opcode == OP_BEQ): begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
        rt_used    = 1'b1;
      end
      (bus.opcode == OP_ADDI): begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Only sources the incoming instruction actually reads can create a hazard.
  always_comb begin
    hazard = 1'b0;
    if (valid_q && ctrl_q.mem_read && (dest_q != '0)) begin
      hazard = (!dec_illegal && (bus.rs == dest_q)) ||
               (rt_used && (bus.rt == dest_q));
    end
  end

  assign in_ready = !flush && !hazard && (state_q == S_RUN) &&
                    (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = accept && is_rtype && (bus.funct == FUNCT_MUL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (state_q == S_MUL) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (is_mul && MUL_MULTI) begin
      state_d = S_MUL;
      cnt_d   = CNT_LOAD;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
      dest_d  = dec.reg_dst ? bus.rd : bus.rt;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic seen_q, seen_d;

  always_comb begin
    illegal_d = illegal_q;
    seen_d    = seen_q;
    if (!flush && accept) begin
      illegal_d = dec_illegal;
      seen_d    = seen_q || dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      seen_q    <= seen_d;
    end
  end

  assign bus.illegal      = illegal_q;
  assign bus.illegal_seen = seen_q;
`else
  assign bus.illegal      = 1'b0;
  assign bus.illegal_seen = 1'b0;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.branch     = ctrl_q.branch;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.dest_reg   = dest_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode, hazards,
// MUL stall, flush, back-pressure, illegal trap and async reset.
module tb_pipelined_control_unit;

  localparam logic [8:0] B_RTYPE = 9'b1_0_0_0_0_0_1_10;
  localparam logic [8:0] B_LW    = 9'b0_0_1_1_0_1_1_00;
  localparam logic [8:0] B_SW    = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] B_BEQ   = 9'b0_1_0_0_0_0_0_01;
  localparam logic [8:0] B_ADDI  = 9'b0_0_0_0_0_1_1_00;
  localparam logic [8:0] B_NOP   = 9'b0;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic clk;
  logic reset;
  logic flush;
  int   total;
  int   bad;

  pipelined_control_unit_if #(.OPCODE_W(6), .REG_W(5)) bus ();

  pipelined_control_unit #(
    .OPCODE_W(6), .REG_W(5), .MUL_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  logic [8:0] bund;
  assign bund = {bus.reg_dst, bus.branch, bus.mem_read,
                 bus.mem_to_reg, bus.mem_write, bus.alu_src,
                 bus.reg_write, bus.alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.rs       = s;
    bus.rt       = t;
    bus.rd       = d;
  endtask

  task automatic idle();
    drive(1'b0, 6'h3F, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic held(input string tag, input logic [8:0] b,
                      input logic [4:0] d);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_bundle"}, 32'(bund), 32'(b));
    chk({tag, "_dest"}, 32'(bus.dest_reg), 32'(d));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    idle();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bundle", 32'(bund), 32'd0);
    chk("rst_dest", 32'(bus.dest_reg), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_seen", 32'(bus.illegal_seen), 32'd0);
    reset = 1'b1;

    // back-to-back decode
    @(negedge clk);
    drive(1'b1, 6'h23, 6'd0, 5'd1, 5'd5, 5'd0);
    #1 chk("lw_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("lw", B_LW, 5'd5);
    drive(1'b1, 6'h08, 6'd0, 5'd2, 5'd6, 5'd0);
    #1 chk("addi_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("addi", B_ADDI, 5'd6);
    drive(1'b1, 6'h2B, 6'd0, 5'd1, 5'd7, 5'd0);
    @(negedge clk);
    held("sw", B_SW, 5'd7);
    drive(1'b1, 6'h04, 6'd0, 5'd1, 5'd2, 5'd0);
    @(negedge clk);
    held("beq", B_BEQ, 5'd2);
    drive(1'b1, 6'h00, 6'd0, 5'd1, 5'd2, 5'd9);
    @(negedge clk);
    held("add", B_RTYPE, 5'd9);
    idle();
    @(negedge clk);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // load-use on rs
    drive(1'b1, 6'h23, 6'd0, 5'd0, 5'd3, 5'd0);
    @(negedge clk);
    held("lu_lw", B_LW, 5'd3);
    drive(1'b1, 6'h00, 6'd0, 5'd3, 5'd4, 5'd8);
    #1 chk("lu_stall", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("lu_bubble", 32'(bus.out_valid), 32'd0);
    #1 chk("lu_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("lu_add", B_RTYPE, 5'd8);

    // LW then ADDI with rt==LW dest: rt not a source of ADDI
    drive(1'b1, 6'h23, 6'd0, 5'd1, 5'd3, 5'd0);
    @(negedge clk);
    held("nh_lw", B_LW, 5'd3);
    drive(1'b1, 6'h08, 6'd0, 5'd1, 5'd3, 5'd0);
    #1 chk("nh_addi_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("nh_addi", B_ADDI, 5'd3);

    // LW to r0 never stalls
    drive(1'b1, 6'h23, 6'd0, 5'd1, 5'd0, 5'd0);
    @(negedge clk);
    held("z_lw", B_LW, 5'd0);
    drive(1'b1, 6'h00, 6'd0, 5'd0, 5'd0, 5'd4);
    #1 chk("z_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("z_add", B_RTYPE, 5'd4);
    idle();
    @(negedge clk);

    // MUL stall: 2 blocked cycles
    drive(1'b1, 6'h00, 6'd2, 5'd1, 5'd2, 5'd10);
    #1 chk("mul_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("mul", B_RTYPE, 5'd10);
    drive(1'b1, 6'h00, 6'd0, 5'd1, 5'd2, 5'd11);
    #1 chk("mul_busy1", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("mul_busy2", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("mul_free", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("mul_next", B_RTYPE, 5'd11);

    // MUL then flush on first busy cycle
    drive(1'b1, 6'h00, 6'd2, 5'd1, 5'd2, 5'd12);
    @(negedge clk);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 6'h08, 6'd0, 5'd1, 5'd14, 5'd0);
    #1 chk("fl_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    chk("fl_kill", 32'(bus.out_valid), 32'd0);
    #1 chk("fl_rdy_after", 32'(bus.in_ready), 32'd1);

    // back-pressure: bundle held 4 cycles, next input waits
    bus.out_ready = 1'b0;
    drive(1'b1, 6'h23, 6'd0, 5'd1, 5'd12, 5'd0);
    @(negedge clk);
    drive(1'b1, 6'h2B, 6'd0, 5'd2, 5'd13, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      held("bp", B_LW, 5'd12);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("bp_sw", B_SW, 5'd13);

    // illegal opcode
    drive(1'b1, 6'h3F, 6'd0, 5'd1, 5'd1, 5'd0);
    @(negedge clk);
    held("ill", B_NOP, 5'd1);
    chk("ill_flag", 32'(bus.illegal), 32'(TRAP));
    chk("ill_seen", 32'(bus.illegal_seen), 32'(TRAP));
    drive(1'b1, 6'h08, 6'd0, 5'd1, 5'd2, 5'd0);
    @(negedge clk);
    held("ill_next", B_ADDI, 5'd2);
    chk("ill_clr", 32'(bus.illegal), 32'd0);
    chk("ill_sticky", 32'(bus.illegal_seen), 32'(TRAP));

    // async reset mid-MUL
    drive(1'b1, 6'h00, 6'd2, 5'd1, 5'd2, 5'd15);
    @(negedge clk);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_bundle", 32'(bund), 32'd0);
    chk("ar_dest", 32'(bus.dest_reg), 32'd0);
    chk("ar_rdy", 32'(bus.in_ready), 32'd1);
    chk("ar_seen", 32'(bus.illegal_seen), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 6'h08, 6'd0, 5'd1, 5'd3, 5'd0);
    #1 chk("ar_run", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    held("ar_addi", B_ADDI, 5'd3);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Registered, handshaked control decoder sitting between the fetch/decode register and the execute stage. It decodes opcode/funct into the control bundle and holds it in an output register with valid/ready flow control. It also detects load-use hazards against the instruction it currently holds and stalls for multi-cycle MUL. Successor to the combinational control unit: wider configurable fields, pipeline handshake, hazard bubble, flush, and an illegal-opcode trap.

## Interface
- OPCODE_W, 6, opcode/funct width
- REG_W, 5, register address width
- MUL_CYCLES, 3, total execute cycles of a MUL (≥1); input blocked for MUL_CYCLES-1 cycles after MUL issue

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- flush  in  1  synchronous kill of held instruction and MUL wait
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  instruction accepted when in_valid && in_ready
- opcode  in  OPCODE_W  primary opcode
- funct  in  OPCODE_W  R-type function (ADD 0, SUB 1, MUL 2)
- rs, rt, rd  in  REG_W  source/dest fields
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute consumes bundle when out_valid && out_ready
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control bits
- alu_op  out  2  00 add, 01 compare, 10 R-type
- dest_reg  out  REG_W  rd if reg_dst else rt
- illegal  out  1  held bundle came from an undefined opcode
- illegal_seen  out  1  sticky status (macro-dependent)

## Operation
- Opcodes: RTYPE 6'h00, BEQ 6'h04, ADDI 6'h08, LW 6'h23, SW 6'h2B; anything else illegal.
- Decode bits per opcode:
  - RTYPE: reg_dst=1, reg_write=1, alu_op=10.
  - LW: mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00.
  - SW: mem_write=1, alu_src=1, alu_op=00.
  - BEQ: branch=1, alu_op=01.
  - ADDI: alu_src=1, reg_write=1, alu_op=00.
  - Unlisted bits are 0. Illegal opcode: all control bits 0 (NOP).
- Source usage for hazard: rs is used by all legal opcodes; rt is used by RTYPE, SW and BEQ only.
- hazard = out_valid && mem_read && held dest_reg≠0 && held dest_reg matches a used source of the incoming instruction.
- in_ready = !flush && !hazard && state==RUN && (!out_valid || out_ready).
- Output register loads on accept. It clears out_valid when drained (out_valid && out_ready) with no accept, which yields exactly one bubble after a load-use hazard.
- FSM:
  - RUN → MUL_BUSY when an RTYPE with funct=2 is accepted and MUL_CYCLES>1; the counter is loaded with MUL_CYCLES-1.
  - MUL_BUSY decrements the counter each cycle and returns to RUN at 0.
  - flush → RUN, counter 0.
- flush: out_valid←0 next edge; in_ready=0 in the flush cycle, so a same-cycle in_valid is dropped; flush wins over accept and hazard.

## Timing
- Latency: accept at edge N → bundle on outputs after edge N, i.e. one cycle. Full throughput, one instruction per cycle, when there is no stall.
- Bundle is held stable while out_valid && !out_ready.
- Load-use: LW held, dependent instruction waits one cycle (bubble), then is accepted.
- MUL: in_ready low for MUL_CYCLES-1 cycles after the MUL accept edge.
- Reset values: out_valid 0, all control bits 0, alu_op 00, dest_reg 0, illegal 0, illegal_seen 0, state RUN, counter 0.
- Reset asserted mid-MUL or mid-stall returns to these values immediately, without waiting for a clock edge.

## Configuration
- CU_ILLEGAL_TRAP_EN defined:
  - An illegal opcode sets illegal=1 with its NOP bundle.
  - illegal_seen sets and stays set until reset.
- CU_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode issues a silent NOP.
  - illegal and illegal_seen are tied to 0.

## Test plan
- Reset release, then LW rt=5, ADDI, SW, BEQ, RTYPE funct=0 back-to-back with out_ready=1 → one bundle per cycle with the exact bit patterns above; dest_reg = 5 for LW and rd for RTYPE.
- LW rt=3 followed by RTYPE rs=3 → in_ready=0 for one cycle, one out_valid=0 bubble, then the RTYPE issues. Repeat with ADDI rt=3, where rt is not a source → no bubble. Repeat with LW rt=0 → no bubble.
- RTYPE funct=2 with MUL_CYCLES=3 → in_ready low for exactly 2 cycles after accept; flush asserted on the first busy cycle → in_ready high on the next cycle.
- out_ready held 0 for 4 cycles with a bundle held → bundle stable, in_ready=0, no input lost.
- opcode 6'h3F with macro defined → NOP bundle, illegal=1, illegal_seen stays 1. Without the macro → NOP bundle with illegal=0.
- reset driven low mid-MUL_BUSY with no clock edge → all outputs at reset values immediately.
